// File: rtl/mod_n_counter.sv
// mod_n_counter
//   Parametrised modulo-N up/down counter with count enable, a synchronous
//   parallel load with range checking, a combinational terminal count for
//   cascading and registered wrap / load-error pulses.
//
// Parameters
//   MODULUS   : count range 0..MODULUS-1, legal 2..2**WIDTH
//   WIDTH     : width of count and load_val
//   RESET_VAL : value forced by reset, must be < MODULUS
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   reset_n   : synchronous active-low reset
//   en        : count enable, one step per enabled cycle
//   up_dn     : 1 = count up, 0 = count down
//   load      : synchronous parallel load (beats en)
//   load_val  : value to load; values >= MODULUS clamp to MODULUS-1
//   sat_mode  : 1 = stop at the range ends instead of wrapping
//   count     : registered count value
//   tc        : combinational terminal count (en & at end in current direction)
//   wrap      : one-cycle pulse the cycle after a wrap
//   load_err  : one-cycle pulse the cycle after an out-of-range load
//
// Configuration macro
//   MOD_N_COUNTER_SAT_EN : when defined, sat_mode enables saturation; when
//                          undefined, sat_mode is ignored and the counter
//                          always wraps.

module mod_n_counter #(
  parameter int MODULUS   = 5,
  parameter int WIDTH     = 3,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  generate
    if (WIDTH < 1 || WIDTH > 30 || MODULUS < 2 || MODULUS > (1 << WIDTH) ||
        RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_param_err
      $fatal(1, "mod_n_counter: illegal MODULUS/WIDTH/RESET_VAL combination");
    end
  endgenerate

  // Range constants kept WIDTH+1 bits wide so MODULUS = 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic             at_max;
  logic             at_zero;
  logic             unused_carry;

  assign count_ext    = {1'b0, count_q};
  assign inc_ext      = count_ext + (WIDTH+1)'(1);
  assign dec_ext      = count_ext - (WIDTH+1)'(1);
  assign at_max       = (count_ext == MAX_EXT);
  assign at_zero      = (count_q == '0);
  // The end-of-range compares guard both directions, so the carry/borrow
  // bits are never needed to decide the next value.
  assign unused_carry = inc_ext[WIDTH] ^ dec_ext[WIDTH];

`ifndef MOD_N_COUNTER_SAT_EN
  logic unused_sat;
  assign unused_sat = sat_mode;
`endif

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        count_d = load_val;
      end else begin
        count_d    = MAX_CNT;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
`ifdef MOD_N_COUNTER_SAT_EN
          if (!sat_mode) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
`else
          count_d = '0;
          wrap_d  = 1'b1;
`endif
        end else begin
          count_d = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
`ifdef MOD_N_COUNTER_SAT_EN
          if (!sat_mode) begin
            count_d = MAX_CNT;
            wrap_d  = 1'b1;
          end
`else
          count_d = MAX_CNT;
          wrap_d  = 1'b1;
`endif
        end else begin
          count_d = dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q    <= RST_CNT;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign tc       = en & ((up_dn & at_max) | (~up_dn & at_zero));

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed testbench for mod_n_counter: a MODULUS=5/WIDTH=3 instance for
// counting, load, priority and saturation checks, and a MODULUS=8/WIDTH=3
// instance for the full-range modulus.

module tb_mod_n_counter;

  logic       clk;
  logic       reset_n, en, up_dn, load, sat_mode;
  logic [2:0] load_val;
  logic [2:0] count;
  logic       tc, wrap, load_err;

  logic       reset8_n, en8;
  logic [2:0] count8;
  logic       tc8, wrap8, load_err8;

  int unsigned n_cmp;
  int unsigned n_err;

  mod_n_counter #(.MODULUS(5), .WIDTH(3), .RESET_VAL(0)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .sat_mode (sat_mode),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  mod_n_counter #(.MODULUS(8), .WIDTH(3), .RESET_VAL(0)) u_dut8 (
    .clk      (clk),
    .reset_n  (reset8_n),
    .en       (en8),
    .up_dn    (1'b1),
    .load     (1'b0),
    .load_val (3'd0),
    .sat_mode (1'b0),
    .count    (count8),
    .tc       (tc8),
    .wrap     (wrap8),
    .load_err (load_err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_dn [5];
    int exp_sat[4];
    int exp_sd [2];
    n_cmp = 0;
    n_err = 0;
    reset_n  = 1'b0;
    en       = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = 3'd0;
    sat_mode = 1'b0;
    reset8_n = 1'b0;
    en8      = 1'b0;

    // Reset for two cycles, then count up for 12 cycles.
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_wrap", wrap, 0);
    check("rst_lerr", load_err, 0);
    reset_n = 1'b1;
    en      = 1'b1;
    up_dn   = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("up_count[%0d]", i), count, i % 5);
      check($sformatf("up_wrap[%0d]", i), wrap, (i == 5 || i == 10) ? 1 : 0);
      check($sformatf("up_tc[%0d]", i), tc, (i % 5 == 4) ? 1 : 0);
      tick();
    end

    // Load 2, then count down.
    en       = 1'b0;
    load     = 1'b1;
    load_val = 3'd2;
    tick();
    load  = 1'b0;
    en    = 1'b1;
    up_dn = 1'b0;
    #1;
    exp_dn = '{2, 1, 0, 4, 3};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("dn_count[%0d]", i), count, exp_dn[i]);
      check($sformatf("dn_wrap[%0d]", i), wrap, (i == 3) ? 1 : 0);
      check($sformatf("dn_tc[%0d]", i), tc, (i == 2) ? 1 : 0);
      if (i < 4) tick();
    end

    // Load range checks, hold, and load beating en.
    en       = 1'b0;
    load     = 1'b1;
    load_val = 3'd6;
    tick();
    check("ld6_count", count, 4);
    check("ld6_lerr", load_err, 1);
    check("ld6_wrap", wrap, 0);
    load = 1'b0;
    tick();
    check("hold_count", count, 4);
    check("hold_lerr", load_err, 0);
    load     = 1'b1;
    load_val = 3'd5;
    tick();
    check("ld5_count", count, 4);
    check("ld5_lerr", load_err, 1);
    load_val = 3'd4;
    tick();
    check("ld4_count", count, 4);
    check("ld4_lerr", load_err, 0);
    en       = 1'b1;
    up_dn    = 1'b1;
    load_val = 3'd3;
    #1;
    check("tc_during_load", tc, 1);
    tick();
    check("ld3_en_count", count, 3);
    check("ld3_en_lerr", load_err, 0);
    check("ld3_en_wrap", wrap, 0);

    // Reset beats simultaneous load and en.
    reset_n  = 1'b0;
    load     = 1'b1;
    load_val = 3'd7;
    en       = 1'b1;
    tick();
    check("rprio_count", count, 0);
    check("rprio_wrap", wrap, 0);
    check("rprio_lerr", load_err, 0);
    reset_n = 1'b1;
    load    = 1'b0;
    en      = 1'b0;

    // Full-range modulus 8.
    tick();
    reset8_n = 1'b1;
    en8      = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("m8_count[%0d]", i), count8, i % 8);
      check($sformatf("m8_wrap[%0d]", i), wrap8, (i == 8) ? 1 : 0);
      check($sformatf("m8_tc[%0d]", i), tc8, (i % 8 == 7) ? 1 : 0);
      tick();
    end
    check("m8_lerr", load_err8, 0);
    en8 = 1'b0;

    // Saturation: up from 3 for 4 cycles, then down from 1 for 2 cycles.
`ifdef MOD_N_COUNTER_SAT_EN
    exp_sat = '{4, 4, 4, 4};
    exp_sd  = '{0, 0};
`else
    exp_sat = '{4, 0, 1, 2};
    exp_sd  = '{0, 4};
`endif
    load     = 1'b1;
    load_val = 3'd3;
    tick();
    check("sat_ld", count, 3);
    load     = 1'b0;
    en       = 1'b1;
    up_dn    = 1'b1;
    sat_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sat_count[%0d]", i), count, exp_sat[i]);
      check($sformatf("sat_wrap[%0d]", i), wrap,
            (exp_sat[i] == 0 && exp_sat[0] != exp_sat[1]) ? 1 : 0);
      check($sformatf("sat_tc[%0d]", i), tc, (exp_sat[i] == 4) ? 1 : 0);
    end
    en       = 1'b0;
    load     = 1'b1;
    load_val = 3'd1;
    tick();
    load  = 1'b0;
    en    = 1'b1;
    up_dn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("satdn_count[%0d]", i), count, exp_sd[i]);
      check($sformatf("satdn_wrap[%0d]", i), wrap, (exp_sd[i] == 4) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
